alu_divider_8bit: RTL and testbench

ALU_DIVIDER_8BIT -- requirements
Module: alu_divider_8bit

---
 rtl/alu_divider_8bit.sv | 142 ++++++++++++++
 tb/tb_alu_divider_8bit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_divider_8bit.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports all-ones quotient with the
// dividend as remainder, flagged by div_by_zero.
module alu_divider_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  // Set for the one IDLE cycle after accepting a zero divisor; the zero test is
  // made on the latched divisor, so DONE is entered one edge after acceptance.
  logic             zpend_q, zpend_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic [WIDTH-1:0] step_rem;
  logic             unused_diff_msb;

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  always_comb begin
    trial     = {prem_q, dvd_q[WIDTH-1]};
    sum       = {1'b0, trial} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
    no_borrow = sum[WIDTH+1];
    // On success the difference is below the divisor, so its top bit is zero;
    // on restore the trial value is below the divisor for the same reason.
    step_rem  = no_borrow ? sum[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  assign unused_diff_msb = sum[WIDTH];

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    zpend_d     = zpend_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    qacc_d      = qacc_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (zpend_q) begin
          zpend_d     = 1'b0;
          quotient_d  = '1;
          remainder_d = dvd_q;
          dbz_d       = 1'b1;
          state_d     = StDone;
        end else if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          qacc_d = '0;
          cnt_d  = '0;
          dbz_d  = 1'b0;
          if (divisor == '0) begin
            zpend_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        prem_d = step_rem;
        qacc_d = {qacc_q[WIDTH-2:0], no_borrow};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          quotient_d  = {qacc_q[WIDTH-2:0], no_borrow};
          remainder_d = step_rem;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      zpend_q     <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      qacc_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      zpend_q     <= zpend_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      qacc_q      <= qacc_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_divider_8bit.sv
// Scoreboard bench for alu_divider_8bit: stimulus pushes expected results
// computed with plain integer division; a forked monitor pops on each done.
module tb_alu_divider_8bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  alu_divider_8bit #(
    .WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned q;
    int unsigned r;
    int unsigned dbz;
    int          acc;
    int          lat;
    int          bsy;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int unsigned last_q = 0;
  int unsigned last_r = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure latency from the accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic division, all-ones/dividend for a zero divisor.
  task automatic push(input int unsigned a, input int unsigned b, input int acc);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.acc = acc;
    if (b == 0) begin
      e.q = 255; e.r = a; e.dbz = 1; e.lat = 1; e.bsy = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 0; e.lat = 8; e.bsy = 8;
    end
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        last_q   = 0;
        last_r   = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 with no request outstanding, expected 0");
          end else begin
            e = sb.pop_front();
            chk($sformatf("quotient %0d/%0d", e.a, e.b), quotient, e.q);
            chk($sformatf("remainder %0d/%0d", e.a, e.b), remainder, e.r);
            chk($sformatf("div_by_zero %0d/%0d", e.a, e.b), div_by_zero, e.dbz);
            chk($sformatf("latency %0d/%0d", e.a, e.b), cyc - e.acc, e.lat);
            chk($sformatf("busy_cycles %0d/%0d", e.a, e.b), busy_cnt, e.bsy);
            last_q = e.q;
            last_r = e.r;
          end
          busy_cnt = 0;
          done_cnt++;
        end else begin
          chk("hold_quotient", quotient, last_q);
          chk("hold_remainder", remainder, last_r);
        end
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // One request; operands are scrambled after acceptance to prove they are latched.
  task automatic do_div(input int unsigned a, input int unsigned b);
    wait_drain();
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 8'(b);
    push(a, b, cyc + 1);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
  endtask

  initial begin
    int d0;
    int unsigned a;
    int unsigned b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;

    // Directed cases including boundaries.
    do_div(100, 7);
    do_div(255, 1);
    do_div(5, 9);
    do_div(200, 200);
    do_div(37, 0);
    do_div(0, 0);
    do_div(0, 255);
    do_div(255, 255);
    do_div(254, 255);
    do_div(1, 1);

    // Reset in the middle of a 100/7 run abandons it without a done pulse.
    wait_drain();
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("midrun_reset");
    repeat (12) @(posedge clk);
    #1;
    do_div(9, 2);

    // start held high with operands changing every cycle.
    wait_drain();
    d0 = done_cnt;
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      dividend = 8'(a);
      divisor  = 8'(b);
      start    = 1'b1;
      if (i % 10 == 0) push(a, b, cyc + 1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("continuous_done_count", done_cnt - d0, 3);

    // Randomized sweep with occasional zero divisors.
    for (int i = 0; i < 500; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 255);
      do_div(a, b);
    end
    wait_drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
